// File: rtl/apb_req_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the
// default widths / timeout used when the top is instantiated bare.
package apb_req_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } apb_req_state_t;

endpackage

// File: rtl/apb_req_timer.sv
// ACCESS-phase cycle counter for the APB requester.
// Ports:
//   PCLK, PRESET : clock and synchronous active-low reset
//   clear        : zero the count (asserted while in SETUP)
//   enable       : count one ACCESS cycle
//   expired      : count has reached TIMEOUT-1, i.e. this is the last allowed cycle
module apb_req_timer
    import apb_req_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT   // must be >= 2
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            // Saturate so a stray extra enable never wraps back to zero.
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: accepts one command at a time, runs a SETUP/ACCESS transfer
// on APB and returns a response, aborting with a timeout if the completer
// holds PREADY low for TIMEOUT ACCESS cycles.
// Ports:
//   PCLK, PRESET            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only when idle)
//   cmd_write/addr/wdata    : command payload, latched on acceptance
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata/err/timeout   : response payload (rdata is 0 for writes/timeouts)
//   PADDR..PENABLE          : APB initiator outputs (registered)
//   PRDATA, PREADY, PSLVERR : APB completer inputs
module apb_requester
    import apb_req_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT   // must be >= 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_req_state_t state;
    logic           out_of_reset;   // low for the cycle(s) following a reset edge
    logic           expired;

    // Holding cmd_ready low until the first non-reset edge keeps it quiet
    // during reset even though the state already reads IDLE.
    assign cmd_ready = (state == S_IDLE) && out_of_reset;

    apb_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (state == S_SETUP),
        .enable  (state == S_ACCESS),
        .expired (expired)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state        <= S_IDLE;
            out_of_reset <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            PWRITE       <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Address/data/direction stay put until the next
                        // accepted command, so they also hold while idle.
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PWRITE  <= cmd_write;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY wins over the timeout in the last allowed cycle.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= S_RESP;
                    end else if (expired) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed corner cases followed by
// randomized transfers, each checked cycle by cycle against expectations
// computed from the transfer's parameters (wait states, error, delay).
module tb_apb_requester;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              PCLK;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_requester #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    // Protocol invariant sampled every cycle away from the edge.
    always @(negedge PCLK) begin
        if (PENABLE === 1'b1) check("penable_needs_psel", PSEL, 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One complete transfer. Expected behaviour comes from the transfer
    // parameters: 'waits' PREADY-low ACCESS cycles before PREADY=1, unless
    // waits >= TIMEOUT, in which case the transfer times out after TIMEOUT cycles.
    task automatic txn(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int waits,
                       input logic [DATA_W-1:0] rdata, input logic serr,
                       input int rdly);
        bit                to;
        int                acc;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
        to      = (waits >= TIMEOUT);
        acc     = to ? TIMEOUT : waits + 1;
        exp_rd  = (wr || to) ? '0 : rdata;
        exp_err = to || serr;

        // Cycle N: idle, command offered.
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = 1'b0; PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        @(negedge PCLK);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("idle_rsp_valid", rsp_valid, 1'b0);
        check("idle_psel", PSEL, 1'b0);
        next_cycle();

        // Cycle N+1: SETUP. Command inputs scrambled; they must be ignored.
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        @(negedge PCLK);
        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wdata);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        next_cycle();

        // ACCESS cycles.
        for (int k = 0; k < acc; k++) begin
            cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
            PREADY  = (k == waits);
            PRDATA  = (k == waits) ? rdata : DATA_W'($urandom);
            PSLVERR = (k == waits) ? serr : 1'($urandom);
            @(negedge PCLK);
            check("access_psel", PSEL, 1'b1);
            check("access_penable", PENABLE, 1'b1);
            check("access_paddr", PADDR, addr);
            check("access_pwdata", PWDATA, wdata);
            check("access_pwrite", PWRITE, wr);
            check("access_rsp_valid", rsp_valid, 1'b0);
            next_cycle();
        end

        // RESP: response held until rsp_ready.
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        for (int d = 0; d <= rdly; d++) begin
            rsp_ready = (d == rdly);
            @(negedge PCLK);
            check("resp_valid", rsp_valid, 1'b1);
            check("resp_rdata", rsp_rdata, exp_rd);
            check("resp_err", rsp_err, exp_err);
            check("resp_timeout", rsp_timeout, to);
            check("resp_psel", PSEL, 1'b0);
            check("resp_penable", PENABLE, 1'b0);
            check("resp_cmd_ready", cmd_ready, 1'b0);
            check("resp_paddr_hold", PADDR, addr);
            next_cycle();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] rd;
        int                w;
        int                r;

        PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) next_cycle();

        // Reset state.
        @(negedge PCLK);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, '0);
        check("rst_pwdata", PWDATA, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        next_cycle();
        PRESET = 1'b1;
        @(negedge PCLK);
        check("rel_cmd_ready_before_edge", cmd_ready, 1'b0);
        next_cycle();
        @(negedge PCLK);
        check("rel_cmd_ready_after_edge", cmd_ready, 1'b1);
        next_cycle();

        // Directed cases.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);             // zero-wait write
        txn(1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);             // 3 wait states read
        txn(1'b0, 32'h24, 32'h0, 1, 32'h12345678, 1'b1, 1);             // PSLVERR on read
        txn(1'b0, 32'h30, 32'h0, TIMEOUT + 5, 32'hCAFEF00D, 1'b0, 0);   // timeout
        txn(1'b0, 32'h34, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5, 1'b0, 0);   // PREADY in last cycle
        txn(1'b1, 32'h38, 32'h01020304, 2, 32'hFFFFFFFF, 1'b0, 5);      // rsp_ready delayed 5

        // Reset during the second ACCESS cycle.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h0; PREADY = 1'b0;
        next_cycle();                      // accepted
        cmd_valid = 1'b0;
        next_cycle();                      // SETUP
        next_cycle();                      // ACCESS cycle 1
        @(negedge PCLK);
        check("mid_rst_in_access", PENABLE, 1'b1);
        PRESET = 1'b0;
        next_cycle();
        @(negedge PCLK);
        check("mid_rst_psel", PSEL, 1'b0);
        check("mid_rst_penable", PENABLE, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        next_cycle();
        PRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("post_rst_no_rsp", rsp_valid, 1'b0);
            check("post_rst_no_psel", PSEL, 1'b0);
            next_cycle();
        end
        txn(1'b0, 32'h48, 32'h0, 0, 32'h87654321, 1'b0, 0);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 3);
            else if (r < 8) w = $urandom_range(4, TIMEOUT - 1);
            else            w = $urandom_range(TIMEOUT, TIMEOUT + 4);
            txn(1'($urandom), a, wd, w, rd, 1'($urandom), $urandom_range(0, 3));
        end

        @(negedge PCLK);
        check("final_cmd_ready", cmd_ready, 1'b1);
        check("final_rsp_valid", rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
